// File: rtl/vga_pattern_gen.sv
// Frame-synchronous VGA test-pattern generator: solid, gradient, bars, checker, grid.
// Two-stage pipeline: stage 1 registers timing and control, stage 2 produces RGB.
module vga_pattern_gen #(
    parameter int COORD_W    = 10,
    parameter int COLOR_W    = 8,
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int CHECK_LOG2 = 5,
    parameter int GRID_LOG2  = 6,
    parameter int FRAME_W    = 8
) (
    input  logic                   clk_pix,
    input  logic                   rst_pix_n,
    input  logic [COORD_W-1:0]     hCount,
    input  logic [COORD_W-1:0]     vCount,
    input  logic                   de,
    input  logic                   hSync,
    input  logic                   vSync,
    input  logic [2:0]             mode_sel,
    input  logic [3*COLOR_W-1:0]   solid_rgb,
    input  logic                   anim_en,
    output logic [COLOR_W-1:0]     r,
    output logic [COLOR_W-1:0]     g,
    output logic [COLOR_W-1:0]     b,
    output logic                   de_o,
    output logic                   hSync_o,
    output logic                   vSync_o,
    output logic [FRAME_W-1:0]     frame_cnt_o
);

    localparam int                 BAR_W    = H_ACTIVE / 8;
    localparam logic [COORD_W-1:0] BAR_LAST = COORD_W'(BAR_W - 1);
    localparam logic [COORD_W-1:0] X_LAST   = COORD_W'(H_ACTIVE - 1);
    localparam logic [COORD_W-1:0] Y_LAST   = COORD_W'(V_ACTIVE - 1);
    localparam logic [COLOR_W-1:0] FULL     = '1;

    logic [COORD_W-1:0]   r_x, r_y;
    logic                 r_de, r_hs, r_vs;
    logic [2:0]           r_mode;
    logic [3*COLOR_W-1:0] r_solid;
    logic [FRAME_W-1:0]   r_frame;
    logic [2:0]           r_bar_idx;
    logic [COORD_W-1:0]   r_bar_px;

    logic [COLOR_W-1:0]   r_r, r_g, r_b;
    logic                 r_de_o, r_hs_o, r_vs_o;

    logic                 w_frame_start;
    logic                 w_grid;
    logic                 w_check;
    logic [COLOR_W-1:0]   w_xc, w_yc;
    logic [COLOR_W-1:0]   w_r, w_g, w_b;
    logic [2:0]           w_bar;

    assign w_frame_start = (hCount == '0) && (vCount == '0);

    // Mode, colour and frame count only change at frame start so a frame is never torn.
    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            r_x       <= '0;
            r_y       <= '0;
            r_de      <= 1'b0;
            r_hs      <= 1'b0;
            r_vs      <= 1'b0;
            r_mode    <= '0;
            r_solid   <= '0;
            r_frame   <= '0;
            r_bar_idx <= '0;
            r_bar_px  <= '0;
        end else begin
            r_x  <= hCount;
            r_y  <= vCount;
            r_de <= de;
            r_hs <= hSync;
            r_vs <= vSync;
            if (w_frame_start) begin
                r_mode  <= mode_sel;
                r_solid <= solid_rgb;
                if (anim_en) begin
                    r_frame <= r_frame + FRAME_W'(1);
                end
            end
            // Bar position tracked incrementally; bar 7 soaks up the H_ACTIVE%8 remainder.
            if (hCount == '0) begin
                r_bar_idx <= '0;
                r_bar_px  <= '0;
            end else if (r_bar_px == BAR_LAST && r_bar_idx != 3'd7) begin
                r_bar_idx <= r_bar_idx + 3'd1;
                r_bar_px  <= '0;
            end else begin
                r_bar_px  <= r_bar_px + COORD_W'(1);
            end
        end
    end

    assign w_xc    = COLOR_W'(r_x);
    assign w_yc    = COLOR_W'(r_y);
    assign w_check = r_x[CHECK_LOG2] ^ r_y[CHECK_LOG2] ^ r_frame[5];
    assign w_grid  = (r_x == '0) || (r_x == X_LAST) || (r_y == '0) || (r_y == Y_LAST) ||
                     (r_x[GRID_LOG2-1:0] == '0) || (r_y[GRID_LOG2-1:0] == '0);

    always_comb begin
        w_r   = '0;
        w_g   = '0;
        w_b   = '0;
        w_bar = 3'b000;
        case (r_bar_idx)
            3'd0:    w_bar = 3'b111;
            3'd1:    w_bar = 3'b110;
            3'd2:    w_bar = 3'b011;
            3'd3:    w_bar = 3'b010;
            3'd4:    w_bar = 3'b101;
            3'd5:    w_bar = 3'b100;
            3'd6:    w_bar = 3'b001;
            default: w_bar = 3'b000;
        endcase
        case (r_mode)
            3'd0: {w_r, w_g, w_b} = r_solid;
            3'd1: begin
                w_r = w_xc + COLOR_W'(r_frame);
                w_g = w_yc;
                w_b = w_xc ^ w_yc;
            end
            3'd2: begin
                w_r = {COLOR_W{w_bar[2]}};
                w_g = {COLOR_W{w_bar[1]}};
                w_b = {COLOR_W{w_bar[0]}};
            end
            3'd3: if (w_check) begin
                w_r = FULL;
                w_g = FULL;
                w_b = FULL;
            end
            3'd4: if (w_grid) begin
                w_r = FULL;
                w_g = FULL;
                w_b = FULL;
            end
            default: ;
        endcase
        if (!r_de) begin
            w_r = '0;
            w_g = '0;
            w_b = '0;
        end
    end

    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            r_r    <= '0;
            r_g    <= '0;
            r_b    <= '0;
            r_de_o <= 1'b0;
            r_hs_o <= 1'b0;
            r_vs_o <= 1'b0;
        end else begin
            r_r    <= w_r;
            r_g    <= w_g;
            r_b    <= w_b;
            r_de_o <= r_de;
            r_hs_o <= r_hs;
            r_vs_o <= r_vs;
        end
    end

    assign r           = r_r;
    assign g           = r_g;
    assign b           = r_b;
    assign de_o        = r_de_o;
    assign hSync_o     = r_hs_o;
    assign vSync_o     = r_vs_o;
    assign frame_cnt_o = r_frame;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Bench for vga_pattern_gen: scoreboard model over short synthetic frames plus spot-check table.
// A second instance with COLOR_W=4, H_ACTIVE=100 covers the bar remainder and narrow colour.
module tb_vga_pattern_gen;

    logic        clk_pix = 1'b0;
    logic        rst_pix_n;
    logic [9:0]  hCount, vCount;
    logic        de, hSync, vSync;
    logic [2:0]  mode_sel, mode_sel4;
    logic [23:0] solid_rgb;
    logic [11:0] solid4;
    logic        anim_en;

    logic [7:0]  r, g, b;
    logic        de_o, hSync_o, vSync_o;
    logic [7:0]  frame_cnt_o;

    logic [3:0]  r4, g4, b4;
    logic        de4, hs4, vs4;
    logic [7:0]  fc4;

    always #5 clk_pix = ~clk_pix;

    vga_pattern_gen dut (
        .clk_pix(clk_pix), .rst_pix_n(rst_pix_n),
        .hCount(hCount), .vCount(vCount),
        .de(de), .hSync(hSync), .vSync(vSync),
        .mode_sel(mode_sel), .solid_rgb(solid_rgb), .anim_en(anim_en),
        .r(r), .g(g), .b(b),
        .de_o(de_o), .hSync_o(hSync_o), .vSync_o(vSync_o),
        .frame_cnt_o(frame_cnt_o)
    );

    vga_pattern_gen #(.COLOR_W(4), .H_ACTIVE(100), .V_ACTIVE(60)) dut4 (
        .clk_pix(clk_pix), .rst_pix_n(rst_pix_n),
        .hCount(hCount), .vCount(vCount),
        .de(de), .hSync(hSync), .vSync(vSync),
        .mode_sel(mode_sel4), .solid_rgb(solid4), .anim_en(anim_en),
        .r(r4), .g(g4), .b(b4),
        .de_o(de4), .hSync_o(hs4), .vSync_o(vs4),
        .frame_cnt_o(fc4)
    );

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic       de;
        logic       hs;
        logic       vs;
    } exp_t;

    typedef struct {
        logic [2:0]  mode;
        logic [23:0] solid;
        int          h;
        int          v;
        logic [23:0] rgb;
    } vec_t;

    exp_t        sb[$];
    vec_t        vt[15];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [2:0]  m_mode;
    logic [23:0] m_solid;
    logic [7:0]  m_frame;

    function automatic exp_t model(input int x, input int y, input bit d, input bit hs, input bit vs);
        exp_t       e;
        int         idx;
        logic [2:0] bar;
        bit         on;
        e    = '0;
        e.de = d;
        e.hs = hs;
        e.vs = vs;
        on   = 1'b0;
        if (d) begin
            case (m_mode)
                3'd0: {e.r, e.g, e.b} = m_solid;
                3'd1: begin
                    e.r = 8'((x + int'(m_frame)) % 256);
                    e.g = 8'(y % 256);
                    e.b = 8'((x ^ y) % 256);
                end
                3'd2: begin
                    idx = x / 80;
                    if (idx > 7) idx = 7;
                    case (idx)
                        0: bar = 3'b111;  1: bar = 3'b110;  2: bar = 3'b011;  3: bar = 3'b010;
                        4: bar = 3'b101;  5: bar = 3'b100;  6: bar = 3'b001;  default: bar = 3'b000;
                    endcase
                    e.r = {8{bar[2]}};
                    e.g = {8{bar[1]}};
                    e.b = {8{bar[0]}};
                end
                3'd3: on = (((x >> 5) ^ (y >> 5) ^ (int'(m_frame) >> 5)) & 1) == 1;
                3'd4: on = (x == 0) || (x == 639) || (y == 0) || (y == 479) || (x % 64 == 0) || (y % 64 == 0);
                default: ;
            endcase
            if (on) {e.r, e.g, e.b} = 24'hFFFFFF;
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One pixel per call: compare what left the pipe, then drive and predict the next pixel.
    task automatic px(input int h, input int v, input bit d, input bit hs, input bit vs,
                      input bit ovr = 1'b0, input logic [23:0] orgb = 24'h0);
        exp_t e;
        @(negedge clk_pix);
        if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard_empty: got none expected entry (t=%0t)", $time);
        end else begin
            e = sb.pop_front();
            chk("pixel_out", 32'({r, g, b, de_o, hSync_o, vSync_o}), 32'(e));
        end
        chk("frame_cnt", 32'(frame_cnt_o), 32'(m_frame));
        hCount = 10'(h);
        vCount = 10'(v);
        de     = d;
        hSync  = hs;
        vSync  = vs;
        if (h == 0 && v == 0) begin
            m_mode  = mode_sel;
            m_solid = solid_rgb;
            if (anim_en) m_frame = m_frame + 8'd1;
        end
        e = model(h, v, d, hs, vs);
        if (ovr) {e.r, e.g, e.b} = orgb;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        hCount = 10'd1;
        vCount = 10'd1;
        de     = 1'b0;
        hSync  = 1'b0;
        vSync  = 1'b0;
        #2 rst_pix_n = 1'b0;
        #1;
        chk("reset_out", 32'({r, g, b, de_o, hSync_o, vSync_o}), 32'h0);
        chk("reset_frame", 32'(frame_cnt_o), 32'h0);
        repeat (2) @(negedge clk_pix);
        rst_pix_n = 1'b1;
        sb.delete();
        sb.push_back('0);
        sb.push_back('0);
        m_mode  = '0;
        m_solid = '0;
        m_frame = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0]  = '{3'd0, 24'h123456, 5,   3,   24'h123456};
        vt[1]  = '{3'd1, 24'h0,      10,  20,  24'h0A141E};
        vt[2]  = '{3'd2, 24'h0,      79,  1,   24'hFFFFFF};
        vt[3]  = '{3'd2, 24'h0,      80,  1,   24'hFFFF00};
        vt[4]  = '{3'd2, 24'h0,      160, 1,   24'h00FFFF};
        vt[5]  = '{3'd2, 24'h0,      559, 1,   24'h0000FF};
        vt[6]  = '{3'd2, 24'h0,      560, 1,   24'h000000};
        vt[7]  = '{3'd2, 24'h0,      639, 1,   24'h000000};
        vt[8]  = '{3'd3, 24'h0,      0,   0,   24'h000000};
        vt[9]  = '{3'd3, 24'h0,      32,  0,   24'hFFFFFF};
        vt[10] = '{3'd3, 24'h0,      32,  32,  24'h000000};
        vt[11] = '{3'd4, 24'h0,      64,  5,   24'hFFFFFF};
        vt[12] = '{3'd4, 24'h0,      65,  5,   24'h000000};
        vt[13] = '{3'd4, 24'h0,      639, 100, 24'hFFFFFF};
        vt[14] = '{3'd6, 24'hABCDEF, 10,  10,  24'h000000};

        rst_pix_n = 1'b0;
        mode_sel  = 3'd0;
        mode_sel4 = 3'd0;
        solid_rgb = 24'h0;
        solid4    = 12'h0;
        anim_en   = 1'b0;
        do_reset();

        // Spot-check table: latch the mode at (0,0), then scan the row up to the target pixel.
        for (int i = 0; i < 15; i++) begin
            mode_sel  = vt[i].mode;
            solid_rgb = vt[i].solid;
            px(0, 0, 1, 0, 0, (vt[i].h == 0 && vt[i].v == 0), vt[i].rgb);
            for (int x = (vt[i].v == 0) ? 1 : 0; x <= vt[i].h; x++)
                px(x, vt[i].v, 1, 0, 0, x == vt[i].h, vt[i].rgb);
            px(700, vt[i].v, 0, 1, 0);
            px(701, vt[i].v, 0, 1, 0);
        end

        // Bottom grid line.
        mode_sel = 3'd4;
        px(0, 0, 1, 0, 0);
        for (int x = 0; x <= 65; x++) px(x, 479, 1, 0, 1, x == 65, 24'hFFFFFF);

        // Deferred mode change mid-frame: grid persists until the next frame start.
        px(0, 0, 1, 0, 0);
        for (int x = 0; x <= 300; x++) begin
            if (x == 100) mode_sel = 3'd2;
            px(x, 200, 1, 0, 0, x == 150, 24'h000000);
        end
        px(0, 0, 1, 0, 0);
        for (int x = 1; x <= 90; x++) px(x, 0, 1, 0, 0);
        for (int x = 0; x <= 90; x++)
            px(x, 1, 1, 0, 0, (x == 79) || (x == 80), (x == 79) ? 24'hFFFFFF : 24'hFFFF00);

        // Gradient animation over three frames.
        mode_sel = 3'd1;
        anim_en  = 1'b1;
        repeat (3) px(0, 0, 1, 0, 0);
        for (int x = 0; x <= 10; x++) px(x, 20, 1, 0, 0, x == 10, 24'h0D141E);
        chk("frame_cnt_after_3", 32'(frame_cnt_o), 32'd3);
        repeat (252) px(0, 0, 1, 0, 0);
        px(1, 0, 1, 0, 0);
        chk("frame_cnt_255", 32'(frame_cnt_o), 32'd255);
        px(0, 0, 1, 0, 0, 1'b1, 24'h000000);
        px(1, 0, 1, 0, 0);
        chk("frame_cnt_wrap", 32'(frame_cnt_o), 32'd0);

        // Checker inverts once frame_cnt[5] is set.
        mode_sel = 3'd3;
        repeat (31) px(0, 0, 1, 0, 0);
        px(0, 0, 1, 0, 0, 1'b1, 24'hFFFFFF);
        for (int x = 1; x <= 32; x++) px(x, 0, 1, 0, 0, x == 32, 24'h000000);
        anim_en = 1'b0;
        repeat (2) px(0, 0, 1, 0, 0);
        chk("frame_cnt_hold", 32'(frame_cnt_o), 32'd32);

        // Grid with random blanking and syncs.
        mode_sel = 3'd4;
        px(0, 0, 1, 0, 0);
        for (int x = 1; x <= 200; x++)
            px(x, 64, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));

        // Reset mid-line: output stays solid-0 (black) until the next frame start.
        for (int x = 0; x <= 50; x++) px(x, 10, 1, 0, 0);
        mode_sel  = 3'd2;
        solid_rgb = 24'hFFFFFF;
        do_reset();
        for (int x = 51; x <= 120; x++) px(x, 10, 1, 0, 0);
        px(0, 0, 1, 0, 0);
        for (int x = 1; x <= 90; x++) px(x, 0, 1, 0, 0, x == 85, 24'hFFFF00);

        // Narrow instance: BAR_W=12, bar 7 spans 84..99.
        mode_sel4 = 3'd2;
        px(0, 0, 1, 0, 0);
        for (int x = 1; x <= 104; x++) begin
            px(x, 0, x < 100, 0, 0);
            case (x - 2)
                11:  chk("p4_bar0_last", 32'({r4, g4, b4}), 32'hFFF);
                12:  chk("p4_bar1_first", 32'({r4, g4, b4}), 32'hFF0);
                71:  chk("p4_bar5_last", 32'({r4, g4, b4}), 32'hF00);
                83:  chk("p4_bar6_last", 32'({r4, g4, b4}), 32'h00F);
                84:  chk("p4_bar7_first", 32'({r4, g4, b4}), 32'h000);
                99:  chk("p4_de_last", 32'(de4), 32'd1);
                100: chk("p4_de_off", 32'(de4), 32'd0);
                default: ;
            endcase
        end
        mode_sel4 = 3'd0;
        solid4    = 12'hF80;
        px(0, 0, 1, 0, 0);
        px(1, 0, 1, 0, 0);
        px(2, 0, 1, 0, 0);
        chk("p4_solid", 32'({r4, g4, b4}), 32'hF80);

        px(700, 0, 0, 0, 0);
        px(701, 0, 0, 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
